fifo_rd_stream: RTL and testbench

- Read-domain consumer of the dual-clock FIFO.
- Drives the FIFO pop and empty handshake, whose read data arrives one cycle after an accepted pop (registered RAM read).
- Presents that data as a registered valid/ready stream to downstream logic.
- A 3-entry internal skid buffer sustains 1 word/cycle with no combinational path from m_ready to r_pop. Also provides a beat counter and a pop-enable gate.

---
 rtl/fifo_rd_stream_pkg.sv | 32 +++
 rtl/fifo_skid_buf.sv | 69 ++++++
 rtl/fifo_rd_stream.sv | 77 +++++++
 tb/tb_fifo_rd_stream.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_stream_pkg.sv
// rtl/fifo_rd_stream_pkg.sv - shared constants, types and helpers for the FIFO read-side stream
package fifo_rd_stream_pkg;

    // Skid buffer depth: one in-flight word plus two stored words of slack
    localparam int SKID_DEPTH = 3;

    // Occupancy counter width (0..3)
    localparam int OCC_WIDTH = 2;

    // Pointer width for the skid buffer slots
    localparam int PTR_WIDTH = 2;

    // Default stream payload width, shared with a write-side counterpart
    localparam int BEAT_DATA_WIDTH = 32;

    typedef logic [PTR_WIDTH-1:0] ptr_t;
    typedef logic [OCC_WIDTH-1:0] occ_t;

    // One stream beat as seen on a valid/ready interface
    typedef struct packed {
        logic                       valid;
        logic [BEAT_DATA_WIDTH-1:0] data;
    } stream_beat_t;

    // Advance a skid pointer, wrapping from the last slot back to slot 0
    function automatic ptr_t ptr_inc(input ptr_t p);
        ptr_t last;
        last = ptr_t'(SKID_DEPTH - 1);
        return (p == last) ? '0 : p + ptr_t'(1);
    endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// rtl/fifo_skid_buf.sv - 3-entry register skid buffer with wrapping pointers and occupancy
module fifo_skid_buf
    import fifo_rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [OCC_WIDTH-1:0]  occ,
    output logic                  not_empty
);

    logic [DATA_WIDTH-1:0] mem [SKID_DEPTH];
    ptr_t                  wr_ptr;
    ptr_t                  rd_ptr;

    // Slot storage: written only on capture; cleared on reset so the head reads 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Write pointer advances on every capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
        end else if (wr_en) begin
            wr_ptr <= ptr_inc(wr_ptr);
        end
    end

    // Read pointer advances on every accepted beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
        end else if (rd_en) begin
            rd_ptr <= ptr_inc(rd_ptr);
        end
    end

    // Occupancy: +1 on capture, -1 on drain, unchanged when both happen together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ <= '0;
        end else begin
            case ({wr_en, rd_en})
                2'b10:   occ <= occ + occ_t'(1);
                2'b01:   occ <= occ - occ_t'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Head of buffer comes straight from a register, never bypassed from wr_data
    always_comb begin
        rd_data   = mem[rd_ptr];
        not_empty = (occ != '0);
    end

endmodule

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - FIFO read-side consumer presenting popped words as a valid/ready stream
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  r_clk,
    input  logic                  rst_n,
    input  logic                  r_empty,
    input  logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_pop,
    input  logic                  pop_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  beat_cnt,
    output logic                  busy
);

    logic                 inflight;
    logic                 pop_req;
    logic                 pop_accept;
    logic                 drain;
    logic [OCC_WIDTH-1:0] occ;
    logic                 buf_not_empty;
    logic [OCC_WIDTH:0]   committed;

    // Pop decision uses only registered state plus r_empty and pop_en, so m_ready
    // never reaches r_pop combinationally. A pop is allowed while the words
    // already committed (stored + in flight) leave a free slot for it.
    always_comb begin
        committed  = {1'b0, occ} + {{OCC_WIDTH{1'b0}}, inflight};
        pop_req    = pop_en & ~r_empty & (committed <= (OCC_WIDTH+1)'(SKID_DEPTH - 1));
        pop_accept = pop_req & ~r_empty;
        r_pop      = pop_req & rst_n;
        drain      = m_valid & m_ready;
    end

    // A word is in flight for exactly one cycle after an accepted pop
    always_ff @(posedge r_clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
        end else begin
            inflight <= pop_accept;
        end
    end

    // Delivered-beat counter, wrapping naturally at its width
    always_ff @(posedge r_clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (drain) begin
            beat_cnt <= beat_cnt + CNT_WIDTH'(1);
        end
    end

    fifo_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk        (r_clk),
        .rst_n      (rst_n),
        .wr_en      (inflight),
        .wr_data    (r_data),
        .rd_en      (drain),
        .rd_data    (m_data),
        .occ        (occ),
        .not_empty  (buf_not_empty)
    );

    // Stream valid and activity status derived from registered state only
    always_comb begin
        m_valid = buf_not_empty;
        busy    = buf_not_empty | inflight;
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - randomized self-checking bench for fifo_rd_stream against a word-level model
module tb_fifo_rd_stream;

    logic        r_clk;
    logic        rst_n;
    logic        r_empty;
    logic [31:0] r_data;
    logic        r_pop;
    logic        pop_en;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [15:0] beat_cnt;
    logic        busy;

    fifo_rd_stream #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
        .r_clk    (r_clk),
        .rst_n    (rst_n),
        .r_empty  (r_empty),
        .r_data   (r_data),
        .r_pop    (r_pop),
        .pop_en   (pop_en),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .beat_cnt (beat_cnt),
        .busy     (busy)
    );

    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    int total = 0;
    int bad   = 0;

    // Word-level model: FIFO contents, words popped but not yet delivered,
    // how many of those have landed, and the delivered-beat count.
    logic [31:0] fifo_q[$];
    logic [31:0] sb[$];
    int          stored;
    logic        in_air;
    logic [15:0] beats_m;
    int          pops_cnt;
    int          cyc;
    logic        s_pop;
    logic        s_valid;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] w);
        fifo_q.push_back(w);
        r_empty = 1'b0;
    endtask

    task automatic model_clear();
        fifo_q.delete();
        sb.delete();
        stored  = 0;
        in_air  = 1'b0;
        beats_m = '0;
    endtask

    // One clock: check outputs mid-cycle, then advance the FIFO and the model
    task automatic cycle();
        logic        exp_pop;
        logic        pop_o;
        logic        acc;
        logic [31:0] w;
        @(negedge r_clk);
        exp_pop = pop_en && !r_empty && ((stored + int'(in_air)) <= 2);
        check("r_pop", r_pop, exp_pop);
        check("m_valid", m_valid, stored != 0);
        if (stored != 0 && sb.size() > 0) check("m_data", m_data, sb[0]);
        check("beat_cnt", beat_cnt, beats_m);
        check("busy", busy, (stored != 0) || in_air);
        pop_o   = r_pop && !r_empty;
        acc     = m_valid && m_ready;
        s_pop   = pop_o;
        s_valid = m_valid;
        w       = $urandom;
        @(posedge r_clk);
        if (acc) begin
            if (sb.size() > 0) void'(sb.pop_front());
            beats_m = beats_m + 16'd1;
        end
        stored = stored + int'(in_air) - int'(acc);
        in_air = pop_o;
        if (pop_o) begin
            if (fifo_q.size() > 0) w = fifo_q.pop_front();
            sb.push_back(w);
            pops_cnt++;
        end
        #1;
        r_data  = w;
        r_empty = (fifo_q.size() == 0);
        cyc++;
    endtask

    task automatic drain(input int maxc);
        int n;
        n       = 0;
        pop_en  = 1'b1;
        m_ready = 1'b1;
        while ((fifo_q.size() > 0 || stored != 0 || in_air) && n < maxc) begin
            cycle();
            n++;
        end
        check("drain_done", (fifo_q.size() == 0) && (stored == 0) && !in_air, 1'b1);
    endtask

    initial begin
        int first_pop;
        int last_pop;
        int first_valid;
        int p0;

        r_empty  = 1'b1;
        r_data   = '0;
        pop_en   = 1'b1;
        m_ready  = 1'b0;
        rst_n    = 1'b1;
        pops_cnt = 0;
        cyc      = 0;
        s_pop    = 1'b0;
        s_valid  = 1'b0;
        model_clear();

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        check("rst_r_pop", r_pop, 1'b0);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_data", m_data, 32'h0);
        check("rst_beat_cnt", beat_cnt, 16'h0);
        check("rst_busy", busy, 1'b0);
        repeat (3) @(posedge r_clk);
        #1 rst_n = 1'b1;

        // 8 preloaded words, sink always ready: back-to-back pops and beats
        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push(32'(i));
        first_pop = -1; last_pop = -1; first_valid = -1; p0 = pops_cnt;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (s_pop) begin
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
            end
            if (s_valid && first_valid < 0) first_valid = cyc;
        end
        check("t1_pops", pops_cnt - p0, 8);
        check("t1_pop_run", last_pop - first_pop + 1, 8);
        check("t1_latency", first_valid - first_pop, 2);
        check("t1_beats", beat_cnt, 16'd8);
        check("t1_idle", busy, 1'b0);

        // 10 words with sink stalled: exactly 3 pops, then release
        m_ready = 1'b0;
        p0 = pops_cnt;
        for (int i = 0; i < 10; i++) push(32'h100 + 32'(i));
        repeat (12) cycle();
        check("t2_pops", pops_cnt - p0, 3);
        check("t2_pop_stopped", s_pop, 1'b0);
        check("t2_head", m_data, 32'h100);
        drain(60);
        check("t2_beats", beat_cnt, 16'd18);

        // Sink toggling 1,0,1,0 with 16 words
        for (int i = 0; i < 16; i++) push(32'h200 + 32'(i));
        for (int i = 0; i < 80 && (fifo_q.size() > 0 || stored != 0 || in_air); i++) begin
            m_ready = ~cyc[0];
            cycle();
        end
        drain(20);
        check("t3_beats", beat_cnt, 16'd34);

        // Empty FIFO: no pops; then a single word
        p0 = pops_cnt;
        repeat (8) cycle();
        check("t4_no_pop", pops_cnt - p0, 0);
        push(32'hCAFE_0001);
        drain(20);
        check("t4_one_pop", pops_cnt - p0, 1);
        check("t4_beats", beat_cnt, 16'd35);

        // pop_en dropped the cycle after a pop: in-flight word still delivered
        p0 = pops_cnt;
        for (int i = 0; i < 5; i++) push(32'h300 + 32'(i));
        for (int i = 0; i < 10 && !s_pop; i++) cycle();
        pop_en = 1'b0;
        repeat (8) cycle();
        check("t5_single_pop", pops_cnt - p0, 1);
        check("t5_beats", beat_cnt, 16'd36);
        drain(40);
        check("t5_beats_all", beat_cnt, 16'd40);

        // Asynchronous reset with two words stored and one in flight
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(32'h400 + 32'(i));
        repeat (3) cycle();
        check("t6_pre_busy", busy, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("t6_r_pop", r_pop, 1'b0);
        check("t6_m_valid", m_valid, 1'b0);
        check("t6_m_data", m_data, 32'h0);
        check("t6_beat_cnt", beat_cnt, 16'h0);
        check("t6_busy", busy, 1'b0);
        model_clear();
        r_empty = 1'b1;
        repeat (2) @(posedge r_clk);
        #1 rst_n = 1'b1;
        m_ready = 1'b1;
        repeat (10) cycle();
        check("t6_quiet", m_valid, 1'b0);

        // Randomized traffic, back-pressure and pop gating
        for (int i = 0; i < 1500; i++) begin
            if (fifo_q.size() < 8 && $urandom_range(2) != 0) push($urandom);
            m_ready = ($urandom_range(3) != 0);
            pop_en  = ($urandom_range(7) != 0);
            cycle();
        end
        drain(100);
        check("rnd_idle", busy, 1'b0);
        check("rnd_beats", beat_cnt, beats_m);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
